instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_seq_pkg.sv | 43 ++++
 rtl/instr_sequencer_addr_stepper.sv | 64 ++++++
 rtl/instr_sequencer.sv | 136 +++++++++++++
 tb/tb_instr_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared constants, field positions, FSM states and the
// beat-count helper for the instruction sequencer.
package instr_seq_pkg;

   localparam int INSTR_W = 26;
   localparam int CNT_W   = 6;

   localparam logic [1:0] OP_MOVE  = 2'b00;
   localparam logic [1:0] OP_BLOCK = 2'b01;
   localparam logic [1:0] OP_IO    = 2'b10;
   localparam logic [1:0] OP_CTRL  = 2'b11;

   localparam int OP_HI  = 25;
   localparam int OP_LO  = 24;
   localparam int SUB_HI = 23;
   localparam int SUB_LO = 22;
   localparam int SRC_HI = 21;
   localparam int SRC_LO = 14;
   localparam int DST_HI = 13;
   localparam int DST_LO = 6;
   localparam int CNT_HI = 5;
   localparam int CNT_LO = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_ISSUE,
      ST_DONE
   } state_e;

   // Moves and block transfers run for count beats (0 means 1); IO/CTRL are single-beat.
   function automatic logic [CNT_W-1:0] calc_beats(input logic [INSTR_W-1:0] w);
      logic [CNT_W-1:0] cnt;
      cnt = w[CNT_HI:CNT_LO];
      case (w[OP_HI:OP_LO])
         OP_MOVE, OP_BLOCK: calc_beats = (cnt == '0) ? CNT_W'(1) : cnt;
         OP_IO, OP_CTRL:    calc_beats = CNT_W'(1);
         default:           calc_beats = CNT_W'(1);
      endcase
   endfunction

endpackage

// File: rtl/instr_sequencer_addr_stepper.sv
// addr_stepper: per-instruction beat offset, remaining-beat down-counter and
// the two 8-bit wrapping address adders. A freshly prefetched word can be
// presented straight from the load inputs before it has been captured.
module addr_stepper
   import instr_seq_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             ld,
   input  logic             fresh,
   input  logic             adv,
   input  logic [7:0]       ld_src,
   input  logic [7:0]       ld_dst,
   input  logic [CNT_W-1:0] ld_beats,
   output logic [7:0]       next_source,
   output logic [7:0]       next_destination,
   output logic             last
);

   logic [7:0]       src_q, src_d;
   logic [7:0]       dst_q, dst_d;
   logic [CNT_W-1:0] off_q, off_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [7:0]       cur_src, cur_dst;
   logic [CNT_W-1:0] cur_off, cur_rem;
   logic [CNT_W-1:0] base_off, base_rem;

   // Current beat view; addresses wrap naturally in 8 bits.
   always_comb begin
      cur_src          = fresh ? ld_src   : src_q;
      cur_dst          = fresh ? ld_dst   : dst_q;
      cur_off          = fresh ? '0       : off_q;
      cur_rem          = fresh ? ld_beats : rem_q;
      next_source      = cur_src + 8'(cur_off);
      next_destination = cur_dst + 8'(cur_off);
      last             = (cur_rem == CNT_W'(1));
   end

   // Load restarts the counters; a consumed non-final beat advances them.
   always_comb begin
      src_d    = ld ? ld_src : src_q;
      dst_d    = ld ? ld_dst : dst_q;
      base_off = ld ? '0 : off_q;
      base_rem = ld ? ld_beats : rem_q;
      off_d    = adv ? base_off + 1'b1 : base_off;
      rem_d    = adv ? base_rem - 1'b1 : base_rem;
   end

   // Counter and base-address registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         src_q <= '0;
         dst_q <= '0;
         off_q <= '0;
         rem_q <= '0;
      end else begin
         src_q <= src_d;
         dst_q <= dst_d;
         off_q <= off_d;
         rem_q <= rem_d;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 26-bit instruction words in order and presents
// each as one or more address beats to a consumer.
// Optional feature macro: INSTR_SEQ_PREFETCH_EN -- reads the next word while
// the final beat is presented so back-to-back instructions have no bubbles.
module instr_sequencer
   import instr_seq_pkg::*;
#(
   parameter int IMEM_DEPTH = 8192,
   parameter int PC_W       = 13
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_rd,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               step_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic [7:0]         next_source,
   output logic [7:0]         next_destination,
   output logic               last_beat,
   output logic               done
);

`ifdef INSTR_SEQ_PREFETCH_EN
   localparam logic PF_EN = 1'b1;
`else
   localparam logic PF_EN = 1'b0;
`endif

   // IMEM_DEPTH must equal 2**PC_W so the last word sits at pc all-ones.
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(IMEM_DEPTH - 1);

   state_e               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 fresh_q, fresh_d;
   logic                 issue, final_beat, pf_rd;
   logic                 stp_ld, stp_adv, stp_last;

   // Output decode; a fresh prefetched word is shown directly from memory
   // during its first cycle and captured at the end of it.
   always_comb begin
      issue       = (state_q == ST_ISSUE);
      final_beat  = issue && stp_last;
      pf_rd       = PF_EN && final_beat && (pc_q != PC_LAST);
      imem_rd     = (state_q == ST_FETCH) || pf_rd;
      imem_addr   = pf_rd ? pc_q + 1'b1 : pc_q;
      instruction = fresh_q ? imem_rdata : instr_q;
      instr_valid = issue;
      last_beat   = final_beat;
      done        = (state_q == ST_DONE);
   end

   // Sequencing: fetch, load, issue beats, then advance pc or finish.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      fresh_d = 1'b0;
      stp_ld  = 1'b0;
      stp_adv = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            instr_d = imem_rdata;
            stp_ld  = 1'b1;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (fresh_q) begin
               instr_d = imem_rdata;
               stp_ld  = 1'b1;
            end
            if (step_ready) begin
               if (!stp_last) begin
                  stp_adv = 1'b1;
               end else begin
                  pc_d = pc_q + 1'b1;
                  if (pc_q == PC_LAST) begin
                     state_d = ST_DONE;
                  end else if (!run) begin
                     state_d = ST_IDLE;
                  end else if (PF_EN) begin
                     state_d = ST_ISSUE;
                     fresh_d = 1'b1;
                  end else begin
                     state_d = ST_FETCH;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, program counter and held instruction.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         fresh_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         fresh_q <= fresh_d;
      end
   end

   addr_stepper u_stepper (
      .clock            (clock),
      .reset            (reset),
      .ld               (stp_ld),
      .fresh            (fresh_q),
      .adv              (stp_adv),
      .ld_src           (imem_rdata[SRC_HI:SRC_LO]),
      .ld_dst           (imem_rdata[DST_HI:DST_LO]),
      .ld_beats         (calc_beats(imem_rdata)),
      .next_source      (next_source),
      .next_destination (next_destination),
      .last             (stp_last)
   );

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table-driven and hand-written sequences on a full-depth
// sequencer, plus randomized runs of a 4-word sequencer checked against a
// beat-list reference model.
module tb_instr_sequencer;

`ifdef INSTR_SEQ_PREFETCH_EN
   localparam int GAP = 0;
`else
   localparam int GAP = 2;
`endif

   logic        clock;
   logic        reset;
   logic        run_a, step_a, rd_a, valid_a, last_a, done_a;
   logic [12:0] addr_a;
   logic [25:0] rdata_a, instr_a;
   logic [7:0]  src_a, dst_a;
   logic        run_b, step_b, rd_b, valid_b, last_b, done_b;
   logic [1:0]  addr_b;
   logic [25:0] rdata_b, instr_b;
   logic [7:0]  src_b, dst_b;

   logic [25:0] mem_a [0:8191];
   logic [25:0] mem_b [0:3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [25:0] word;
      int          nbeats;
      logic [7:0]  src0;
      logic [7:0]  dst0;
   } vec_t;

   typedef struct {
      logic [25:0] word;
      logic [7:0]  src;
      logic [7:0]  dst;
      logic        last;
   } beat_t;

   vec_t  tbl [6];
   beat_t exp_q [$];

   instr_sequencer u_dut (
      .clock(clock), .reset(reset), .run(run_a),
      .imem_addr(addr_a), .imem_rd(rd_a), .imem_rdata(rdata_a),
      .step_ready(step_a), .instruction(instr_a), .instr_valid(valid_a),
      .next_source(src_a), .next_destination(dst_a),
      .last_beat(last_a), .done(done_a)
   );

   instr_sequencer #(.IMEM_DEPTH(4), .PC_W(2)) u_small (
      .clock(clock), .reset(reset), .run(run_b),
      .imem_addr(addr_b), .imem_rd(rd_b), .imem_rdata(rdata_b),
      .step_ready(step_b), .instruction(instr_b), .instr_valid(valid_b),
      .next_source(src_b), .next_destination(dst_b),
      .last_beat(last_b), .done(done_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous-read memories: data appears the cycle after the strobe.
   always @(posedge clock) if (rd_a) rdata_a <= mem_a[addr_a];
   always @(posedge clock) if (rd_b) rdata_b <= mem_b[addr_b];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [25:0] mk(input logic [1:0] op, input logic [7:0] s,
                                      input logic [7:0] d, input logic [5:0] c);
      return {op, 2'b01, s, d, c};
   endfunction

   // Reference: the full ordered beat list implied by the 4-word memory.
   task automatic build_model();
      exp_q.delete();
      for (int w = 0; w < 4; w++) begin
         int n;
         logic [25:0] word;
         word = mem_b[w];
         if (word[25:24] >= 2'd2) n = 1;
         else if (word[5:0] == 6'd0) n = 1;
         else n = int'(word[5:0]);
         for (int k = 0; k < n; k++) begin
            beat_t e;
            e.word = word;
            e.src  = 8'((int'(word[21:14]) + k) % 256);
            e.dst  = 8'((int'(word[13:6]) + k) % 256);
            e.last = (k == n - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_valid_a(input string name);
      int n = 0;
      while (!valid_a && n < 20) begin
         tick();
         n++;
      end
      check(name, valid_a, 1'b1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int gap;
      reset  = 1'b1;
      run_a  = 1'b0;
      step_a = 1'b0;
      run_b  = 1'b0;
      step_b = 1'b0;
      for (int i = 0; i < 8192; i++) mem_a[i] = '0;
      for (int i = 0; i < 4; i++) mem_b[i] = '0;
      tick();
      tick();

      // Reset state
      check("rst_valid", valid_a, 1'b0);
      check("rst_instr", instr_a, 26'd0);
      check("rst_rd", rd_a, 1'b0);
      check("rst_addr", addr_a, 13'd0);
      check("rst_last", last_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_src", src_a, 8'd0);
      check("rst_dst", dst_a, 8'd0);
      check("rst_done_b", done_b, 1'b0);

      // Table-driven back-to-back instructions with step_ready held high
      tbl[0] = '{mk(2'b00, 8'h10, 8'h40, 6'd3), 3, 8'h10, 8'h40};
      tbl[1] = '{mk(2'b01, 8'hFE, 8'h20, 6'd4), 4, 8'hFE, 8'h20};
      tbl[2] = '{mk(2'b00, 8'h33, 8'h44, 6'd0), 1, 8'h33, 8'h44};
      tbl[3] = '{mk(2'b10, 8'h55, 8'h66, 6'd5), 1, 8'h55, 8'h66};
      tbl[4] = '{mk(2'b11, 8'h77, 8'h88, 6'd0), 1, 8'h77, 8'h88};
      tbl[5] = '{mk(2'b01, 8'hFF, 8'hFF, 6'd2), 2, 8'hFF, 8'hFF};
      for (int i = 0; i < 6; i++) mem_a[i] = tbl[i].word;
      reset  = 1'b0;
      run_a  = 1'b1;
      step_a = 1'b1;
      lat = 0;
      while (!valid_a && lat < 10) begin
         tick();
         lat++;
      end
      check("latency", lat, 3);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            gap = 0;
            while (!valid_a && gap < 10) begin
               tick();
               gap++;
            end
            check("gap", gap, GAP);
         end
         for (int b = 0; b < tbl[i].nbeats; b++) begin
            logic [7:0] es, ed;
            es = tbl[i].src0 + 8'(b);
            ed = tbl[i].dst0 + 8'(b);
            check("tbl_valid", valid_a, 1'b1);
            check("tbl_instr", instr_a, tbl[i].word);
            check("tbl_src", src_a, es);
            check("tbl_dst", dst_a, ed);
            check("tbl_last", last_a, (b == tbl[i].nbeats - 1));
            tick();
         end
      end
      run_a = 1'b0;
      for (int i = 0; i < 8; i++) tick();

      // Consumer stall for 4 cycles in the middle of a 5-beat block
      reset = 1'b1;
      tick();
      mem_a[0] = mk(2'b01, 8'h20, 8'h80, 6'd5);
      reset = 1'b0;
      run_a = 1'b1;
      step_a = 1'b1;
      wait_valid_a("stall_wait");
      tick();
      tick();
      step_a = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("stall_hold", {valid_a, instr_a, src_a, dst_a, last_a},
               {1'b1, mem_a[0], 8'h22, 8'h82, 1'b0});
         tick();
      end
      step_a = 1'b1;
      for (int b = 2; b < 5; b++) begin
         check("stall_beat", {valid_a, src_a, dst_a, last_a},
               {1'b1, 8'(8'h20 + b), 8'(8'h80 + b), (b == 4)});
         tick();
      end
      run_a = 1'b0;
      for (int i = 0; i < 6; i++) tick();

      // Reset on the 2nd beat of a 5-beat instruction
      reset = 1'b1;
      tick();
      mem_a[0] = mk(2'b00, 8'h50, 8'h60, 6'd5);
      mem_a[1] = mk(2'b10, 8'h01, 8'h02, 6'd0);
      reset = 1'b0;
      run_a = 1'b1;
      step_a = 1'b1;
      wait_valid_a("mrst_wait");
      tick();
      check("mrst_beat2", src_a, 8'h51);
      reset = 1'b1;
      tick();
      check("mrst_zero", {instr_a, valid_a, rd_a, addr_a, last_a, done_a, src_a, dst_a}, 64'd0);
      reset = 1'b0;
      lat = 0;
      while (!rd_a && lat < 10) begin
         tick();
         lat++;
      end
      check("mrst_rd", rd_a, 1'b1);
      check("mrst_addr", addr_a, 13'd0);
      wait_valid_a("mrst_wait2");
      check("mrst_restart", {src_a, dst_a}, {8'h50, 8'h60});
      run_a = 1'b0;
      for (int i = 0; i < 8; i++) tick();

      // Depth-4 sequencer with run held high: gaps and done
      reset = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) mem_b[i] = mk(2'b10, 8'(i * 16), 8'(i * 3), 6'(i + 2));
      reset = 1'b0;
      run_b = 1'b1;
      step_b = 1'b1;
      begin
         int  seen = 0;
         bit  first = 1'b1;
         gap = 0;
         for (int c = 0; c < 40 && !done_b; c++) begin
            if (valid_b) begin
               if (seen < 4) check("d4_word", instr_b, mem_b[seen]);
               if (!first) check("d4_gap", gap, GAP);
               first = 1'b0;
               gap = 0;
               seen++;
            end else if (!first) begin
               gap++;
            end
            tick();
         end
         check("d4_count", seen, 4);
      end
      check("d4_done", done_b, 1'b1);
      run_b = 1'b0;
      tick();
      tick();
      check("d4_done_idle", {done_b, valid_b, rd_b}, {1'b1, 1'b0, 1'b0});
      run_b = 1'b1;
      tick();
      tick();
      check("d4_done_run", {done_b, valid_b, rd_b}, {1'b1, 1'b0, 1'b0});

      // Randomized runs against the beat-list model
      for (int r = 0; r < 8; r++) begin
         int    rst_at;
         bit    p_ok;
         logic  p_valid, p_cons, p_last;
         logic [25:0] p_instr;
         logic [7:0]  p_src, p_dst;
         for (int i = 0; i < 4; i++)
            mem_b[i] = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        6'($urandom_range(0, 7))};
         build_model();
         rst_at = (r % 2 == 1) ? int'($urandom_range(5, 30)) : -1;
         reset = 1'b1;
         tick();
         reset = 1'b0;
         p_ok = 1'b0;
         p_valid = 1'b0;
         p_cons = 1'b0;
         p_last = 1'b0;
         p_instr = '0;
         p_src = '0;
         p_dst = '0;
         for (int c = 0; c < 1500 && !done_b; c++) begin
            logic cons;
            run_b  = ($urandom_range(0, 3) != 0);
            step_b = 1'($urandom_range(0, 1));
            if (p_ok && p_valid && !p_cons)
               check("rnd_hold", {valid_b, instr_b, src_b, dst_b, last_b},
                     {1'b1, p_instr, p_src, p_dst, p_last});
            if (c == rst_at) begin
               reset = 1'b1;
               tick();
               reset = 1'b0;
               check("rnd_rst", {valid_b, instr_b, last_b, rd_b}, 64'd0);
               build_model();
               p_ok = 1'b0;
               continue;
            end
            cons = valid_b && step_b;
            if (cons) begin
               if (exp_q.size() == 0) begin
                  check("rnd_extra_beat", valid_b, 1'b0);
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  check("rnd_beat", {instr_b, src_b, dst_b, last_b},
                        {e.word, e.src, e.dst, e.last});
               end
            end
            p_ok = 1'b1;
            p_valid = valid_b;
            p_cons = cons;
            p_instr = instr_b;
            p_src = src_b;
            p_dst = dst_b;
            p_last = last_b;
            tick();
         end
         check("rnd_done", done_b, 1'b1);
         check("rnd_left", exp_q.size(), 0);
         check("rnd_done_valid", valid_b, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
